multicycle_alu: RTL and testbench
=================================

MULTICYCLE_ALU -- requirements
Module: multicycle_alu

Interface
REQ-001 Parameter N, default 8, operand/result width in bits; legal range N >= 4.
REQ-002 The block SHALL expose the following ports, clock and reset first.
- clk  input  1  single clock; all state changes on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  operation request; sampled on a rising edge together with a, b and ctrl.
- a  input  N  operand A.
- b  input  N  operand B; also the shift amount.
- ctrl  input  4  operation select.
- ready  output  1  block can accept start.
- busy  output  1  iterative operation in progress.
- done  output  1  one-cycle pulse; result/flags valid.
- result  output  N  operation result.
- flags  output  4  {Neg, Carry, oVerflow, Zero} = flags[3:0].
REQ-003 The design SHALL use one clock; reset SHALL be asynchronous and active-low.

Function
REQ-004 Operations SHALL decode from ctrl as follows.
- Single-cycle: 0000 ADD; 0001 SUB (a-b); 0010 AND; 0011 OR; 0110 SHR (logical); 0111 SHL; 1000 XOR; 1001 ASR (arithmetic right).
- Iterative: 0100 MOD (unsigned a%b); 0101 MUL (unsigned, low N bits).
- Any other ctrl code: result 0, flags 4'b0001.
REQ-005 Operation acceptance SHALL follow these rules.
- Accept = start & ready at a rising edge.
- a, b and ctrl SHALL be latched at the accept edge; later input changes SHALL have no effect on that operation.
REQ-006 State machine SHALL have states IDLE, MUL, DIV.
- IDLE->MUL on accept with MUL.
- IDLE->DIV on accept with MOD.
- Single-cycle ops and illegal codes remain in IDLE.
- MUL/DIV->IDLE after the N-th iteration edge.
REQ-007 ready SHALL equal (state==IDLE); busy SHALL equal (state!=IDLE).
REQ-008 Latency SHALL be measured from the accept edge k.
- Single-cycle ops: done=1 in the cycle following edge k.
- MUL/MOD: one iteration per edge k+1..k+N; done=1 in the cycle following edge k+N.
REQ-009 done SHALL be high for exactly one cycle per accepted operation; result and flags SHALL hold their values until the next done.
REQ-010 ready SHALL be high during the done cycle, so back-to-back operations are accepted with no gap cycle.
REQ-011 start while busy=1 SHALL be ignored and SHALL not be queued.
REQ-012 MUL SHALL be a shift-add over N iterations of a 2N-bit product; result = product[N-1:0].
REQ-013 MOD SHALL be restoring division over N iterations; result = remainder.
REQ-014 MOD with b==0 SHALL still take N iterations and SHALL return result=a and V=1.
REQ-015 Shift amount SHALL be the unsigned value of b.
- b >= N: SHR and SHL give 0; ASR gives all bits equal to a[N-1].
REQ-016 Flag Z SHALL be (result==0); flag Neg SHALL be result[N-1]; both apply to all ops.
REQ-017 Flag C SHALL be set as follows.
- ADD: carry-out.
- SUB: borrow (a<b unsigned).
- MUL: product[2N-1:N] != 0.
- All other ops: 0.
REQ-018 Flag V SHALL be set as follows.
- ADD/SUB: two's-complement signed overflow.
- MOD: divide-by-zero.
- All other ops: 0.

Reset
REQ-019 rst_n=0 SHALL immediately force state=IDLE, result=0, flags=0, done=0, busy=0 and ready=1, including mid-MUL/MOD; the aborted operation SHALL produce no done.
REQ-020 The first accept SHALL be possible at the first rising edge after rst_n deasserts.

Verification (N=8)
REQ-021 ADD a=8'h7F b=8'h01 -> one cycle later: done=1, result=8'h80, flags=4'b1010.
REQ-022 SUB a=8'h00 b=8'h01 -> result=8'hFF, flags=4'b1100; then ASR a=8'h80 b=8'd9 -> result=8'hFF, flags=4'b1000.
REQ-023 MUL a=8'h10 b=8'h20 -> busy for 8 cycles, done in the cycle after edge k+8, result=8'h00, flags=4'b0101; start pulsed mid-operation is ignored.
REQ-024 MOD a=8'd100 b=8'd7 -> result=8'd2, flags=4'b0000; MOD a=8'd100 b=0 -> result=8'd100, flags=4'b0010, same latency.
REQ-025 rst_n pulsed low at iteration 4 of MUL -> outputs zero at once, no done pulse; ADD 3+4 at the next edge -> result=8'd7, flags=4'b0000.

Source files
------------

// File: rtl/multicycle_alu.sv
// Multicycle ALU: single-cycle logic/arith/shift ops plus N-iteration
// shift-add multiply and restoring-division modulo, with NCVZ flags.
module multicycle_alu #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [3:0]   ctrl,
  output logic         ready,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] result,
  output logic [3:0]   flags
);

  localparam int CW = $clog2(N);

  typedef logic [N-1:0]  word_t;
  typedef logic [CW-1:0] cnt_t;

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_e;

  typedef enum logic [3:0] {
    OP_ADD = 4'b0000, OP_SUB = 4'b0001, OP_AND = 4'b0010, OP_OR  = 4'b0011,
    OP_MOD = 4'b0100, OP_MUL = 4'b0101, OP_SHR = 4'b0110, OP_SHL = 4'b0111,
    OP_XOR = 4'b1000, OP_ASR = 4'b1001
  } op_e;

  state_e        state_q, state_d;
  cnt_t          cnt_q, cnt_d;
  word_t         a_q, a_d, b_q, b_d;
  logic [2*N-1:0] prod_q, prod_d;
  word_t         rem_q, rem_d, quo_q, quo_d;
  word_t         result_q, result_d;
  logic [3:0]    flags_q, flags_d;
  logic          done_q, done_d;

  // Single-cycle datapath, evaluated on the live inputs at the accept edge
  word_t  sc_res;
  logic   sc_c, sc_v, big_shift;
  logic [N:0] sum_ext, diff_ext;

  always_comb begin
    sc_res    = '0;
    sc_c      = 1'b0;
    sc_v      = 1'b0;
    big_shift = (b >= word_t'(N));
    sum_ext   = {1'b0, a} + {1'b0, b};
    diff_ext  = {1'b0, a} - {1'b0, b};
    case (ctrl)
      OP_ADD: begin
        sc_res = sum_ext[N-1:0];
        sc_c   = sum_ext[N];
        sc_v   = (a[N-1] == b[N-1]) && (sum_ext[N-1] != a[N-1]);
      end
      OP_SUB: begin
        sc_res = diff_ext[N-1:0];
        sc_c   = diff_ext[N];
        sc_v   = (a[N-1] != b[N-1]) && (diff_ext[N-1] != a[N-1]);
      end
      OP_AND: sc_res = a & b;
      OP_OR:  sc_res = a | b;
      OP_XOR: sc_res = a ^ b;
      OP_SHR: sc_res = big_shift ? '0 : (a >> b);
      OP_SHL: sc_res = big_shift ? '0 : (a << b);
      OP_ASR: sc_res = big_shift ? {N{a[N-1]}} : word_t'($signed(a) >>> b);
      default: sc_res = '0;
    endcase
  end

  // One iteration of each multicycle algorithm
  logic [N:0]     mul_sum;
  logic [2*N-1:0] mul_next;
  logic [N:0]     div_shift;
  word_t          div_sub, rem_next, quo_next, iter_res;
  logic           div_ge;

  always_comb begin
    mul_sum   = {1'b0, prod_q[2*N-1:N]} + (prod_q[0] ? {1'b0, a_q} : '0);
    mul_next  = {mul_sum, prod_q[N-1:1]};
    div_shift = {rem_q, quo_q[N-1]};
    div_ge    = (div_shift >= {1'b0, b_q});
    div_sub   = div_shift[N-1:0] - b_q;
    rem_next  = div_ge ? div_sub : div_shift[N-1:0];
    quo_next  = {quo_q[N-2:0], div_ge};
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    prod_d   = prod_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    result_d = result_q;
    flags_d  = flags_q;
    done_d   = 1'b0;
    iter_res = '0;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d   = a;
          b_d   = b;
          cnt_d = '0;
          if (ctrl == OP_MUL) begin
            prod_d  = {{N{1'b0}}, b};
            state_d = MUL;
          end else if (ctrl == OP_MOD) begin
            rem_d   = '0;
            quo_d   = a;
            state_d = DIV;
          end else begin
            result_d = sc_res;
            flags_d  = {sc_res[N-1], sc_c, sc_v, sc_res == '0};
            done_d   = 1'b1;
          end
        end
      end
      MUL: begin
        prod_d = mul_next;
        cnt_d  = cnt_q + cnt_t'(1);
        if (cnt_q == cnt_t'(N - 1)) begin
          iter_res = mul_next[N-1:0];
          result_d = iter_res;
          flags_d  = {iter_res[N-1], |mul_next[2*N-1:N], 1'b0, iter_res == '0};
          done_d   = 1'b1;
          state_d  = IDLE;
        end
      end
      DIV: begin
        rem_d = rem_next;
        quo_d = quo_next;
        cnt_d = cnt_q + cnt_t'(1);
        if (cnt_q == cnt_t'(N - 1)) begin
          // Divide-by-zero returns the dividend rather than the shifted garbage
          iter_res = (b_q == '0) ? a_q : rem_next;
          result_d = iter_res;
          flags_d  = {iter_res[N-1], 1'b0, b_q == '0, iter_res == '0};
          done_d   = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      prod_q   <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      result_q <= '0;
      flags_q  <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      prod_q   <= prod_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      result_q <= result_d;
      flags_q  <= flags_d;
      done_q   <= done_d;
    end
  end

  assign ready  = (state_q == IDLE);
  assign busy   = (state_q != IDLE);
  assign done   = done_q;
  assign result = result_q;
  assign flags  = flags_q;

endmodule

// File: tb/tb_multicycle_alu.sv
// Directed self-checking bench for multicycle_alu at N=8.
module tb_multicycle_alu;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic [3:0] ctrl = '0;
  logic       ready, busy, done;
  logic [7:0] result;
  logic [3:0] flags;

  int unsigned total = 0;
  int unsigned bad = 0;

  multicycle_alu #(.N(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .ctrl(ctrl),
    .ready(ready), .busy(busy), .done(done), .result(result), .flags(flags)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one op, scramble inputs after accept, then measure latency and busy
  // cycles. With inject set, a start is pulsed while the op is in flight.
  task automatic run_op(input string tag, input logic [3:0] c, input logic [7:0] x,
                        input logic [7:0] y, input int exp_lat, input logic [7:0] exp_res,
                        input logic [3:0] exp_fl, input bit inject);
    int lat;
    int busy_cnt;
    @(negedge clk);
    check({tag, " ready"}, 32'(ready), 32'd1);
    start = 1'b1; a = x; b = y; ctrl = c;
    @(posedge clk); #1;
    start = 1'b0; a = 8'($urandom); b = 8'($urandom); ctrl = 4'($urandom);
    lat = 1;
    busy_cnt = 0;
    while (!done && lat < 40) begin
      if (busy) busy_cnt++;
      if (inject && lat == 3) begin
        start = 1'b1; ctrl = 4'b0000; a = 8'd1; b = 8'd1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check({tag, " busy cycles"}, 32'(busy_cnt), 32'(exp_lat - 1));
    check({tag, " result"}, 32'(result), 32'(exp_res));
    check({tag, " flags"}, 32'(flags), 32'(exp_fl));
    check({tag, " ready at done"}, 32'(ready), 32'd1);
  endtask

  initial begin
    #1;
    check("reset ready", 32'(ready), 32'd1);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset result", 32'(result), 32'd0);
    check("reset flags", 32'(flags), 32'd0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    run_op("add 7f+01", 4'b0000, 8'h7F, 8'h01, 1, 8'h80, 4'b1010, 1'b0);
    run_op("sub 00-01", 4'b0001, 8'h00, 8'h01, 1, 8'hFF, 4'b1100, 1'b0);
    run_op("asr 80>>>9", 4'b1001, 8'h80, 8'd9, 1, 8'hFF, 4'b1000, 1'b0);
    run_op("mul 10*20", 4'b0101, 8'h10, 8'h20, 9, 8'h00, 4'b0101, 1'b1);
    @(posedge clk); #1;
    check("mul no queued op", 32'(done), 32'd0);
    check("mul result hold", 32'(result), 32'h00);
    run_op("mod 100%7", 4'b0100, 8'd100, 8'd7, 9, 8'd2, 4'b0000, 1'b0);
    run_op("mod 100%0", 4'b0100, 8'd100, 8'd0, 9, 8'd100, 4'b0010, 1'b0);
    @(posedge clk); #1;
    check("done one cycle", 32'(done), 32'd0);
    check("result hold", 32'(result), 32'd100);
    check("flags hold", 32'(flags), 32'b0010);

    run_op("and", 4'b0010, 8'hF0, 8'h3C, 1, 8'h30, 4'b0000, 1'b0);
    run_op("or", 4'b0011, 8'h0F, 8'hF0, 1, 8'hFF, 4'b1000, 1'b0);
    run_op("xor zero", 4'b1000, 8'hAA, 8'hAA, 1, 8'h00, 4'b0001, 1'b0);
    run_op("shr 1", 4'b0110, 8'h81, 8'd1, 1, 8'h40, 4'b0000, 1'b0);
    run_op("shr 8", 4'b0110, 8'h81, 8'd8, 1, 8'h00, 4'b0001, 1'b0);
    run_op("shl 1", 4'b0111, 8'h81, 8'd1, 1, 8'h02, 4'b0000, 1'b0);
    run_op("shl 200", 4'b0111, 8'h81, 8'd200, 1, 8'h00, 4'b0001, 1'b0);
    run_op("asr c0>>>2", 4'b1001, 8'hC0, 8'd2, 1, 8'hF0, 4'b1000, 1'b0);
    run_op("asr 40>>>8", 4'b1001, 8'h40, 8'd8, 1, 8'h00, 4'b0001, 1'b0);
    run_op("add carry", 4'b0000, 8'hFF, 8'h01, 1, 8'h00, 4'b0101, 1'b0);
    run_op("sub ovf", 4'b0001, 8'h80, 8'h01, 1, 8'h7F, 4'b0010, 1'b0);
    run_op("mul ff*ff", 4'b0101, 8'hFF, 8'hFF, 9, 8'h01, 4'b0100, 1'b0);
    run_op("mul 3*5", 4'b0101, 8'h03, 8'h05, 9, 8'h0F, 4'b0000, 1'b0);
    run_op("mod 15%16", 4'b0100, 8'h0F, 8'h10, 9, 8'h0F, 4'b0000, 1'b0);
    run_op("mod ff%16", 4'b0100, 8'hFF, 8'h10, 9, 8'h0F, 4'b0000, 1'b0);
    run_op("illegal a", 4'b1010, 8'h12, 8'h34, 1, 8'h00, 4'b0001, 1'b0);
    run_op("illegal f", 4'b1111, 8'hFF, 8'hFF, 1, 8'h00, 4'b0001, 1'b0);

    // Abort a multiply partway through with reset
    run_op("pre-reset sub", 4'b0001, 8'h09, 8'h02, 1, 8'h07, 4'b0000, 1'b0);
    @(negedge clk);
    start = 1'b1; ctrl = 4'b0101; a = 8'h03; b = 8'h05;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort busy", 32'(busy), 32'd0);
    check("abort ready", 32'(ready), 32'd1);
    check("abort done", 32'(done), 32'd0);
    check("abort result", 32'(result), 32'd0);
    check("abort flags", 32'(flags), 32'd0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    run_op("add after reset", 4'b0000, 8'd3, 8'd4, 1, 8'd7, 4'b0000, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
